// File: rtl/bnn_layer_sequencer.sv
// Layer sequencer for a binary NN compute engine: walks a host-written layer table,
// issues one engine run per output neuron and ping-pongs two activation banks.
module bnn_layer_sequencer #(
  parameter  int W_ADDR_LEN = 17,
  parameter  int I_ADDR_LEN = 10,
  parameter  int MAX_LAYERS = 4,
  parameter  int TIMEOUT    = 4096,
  localparam int LIDX_W     = $clog2(MAX_LAYERS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cfg_we,
  input  logic [LIDX_W-1:0]     i_cfg_idx,
  input  logic [I_ADDR_LEN:0]   i_cfg_n_in,
  input  logic [I_ADDR_LEN:0]   i_cfg_n_out,
  input  logic [W_ADDR_LEN-1:0] i_cfg_w_base,
  input  logic [LIDX_W:0]       i_num_layers,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_result_bank,
  output logic                  o_eng_start,
  input  logic                  i_eng_finish,
  output logic [W_ADDR_LEN-1:0] o_eng_w_base,
  output logic [I_ADDR_LEN:0]   o_eng_n_in,
  output logic                  o_eng_in_bank,
  output logic [I_ADDR_LEN-1:0] o_eng_out_addr
);

  localparam int NW    = I_ADDR_LEN + 1;
  localparam int LW    = LIDX_W + 1;
  localparam int PW    = W_ADDR_LEN + I_ADDR_LEN + 2;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [NW-1:0]    N_MAX = {1'b1, {I_ADDR_LEN{1'b0}}};
  localparam logic [PW-1:0]    W_LIM = PW'(1) << W_ADDR_LEN;
  localparam logic [LW-1:0]    L_MAX = LW'(MAX_LAYERS);
  localparam logic [TMO_W-1:0] T_END = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_NEXT_N, S_NEXT_L, S_DONE
  } state_t;

  state_t                r_state;
  logic [NW-1:0]         r_tbl_n_in  [MAX_LAYERS];
  logic [NW-1:0]         r_tbl_n_out [MAX_LAYERS];
  logic [W_ADDR_LEN-1:0] r_tbl_w_base[MAX_LAYERS];
  logic [LW-1:0]         r_num_layers;
  logic [LIDX_W-1:0]     r_layer;
  logic [NW-1:0]         r_neuron;
  logic [NW-1:0]         r_n_in;
  logic [NW-1:0]         r_n_out;
  logic [W_ADDR_LEN-1:0] r_w_ptr;
  logic                  r_bank;
  logic [TMO_W-1:0]      r_tmo;

  logic [NW-1:0]         w_n_in;
  logic [NW-1:0]         w_n_out;
  logic [PW-1:0]         w_end;
  logic                  w_cfg_bad;

  assign w_n_in  = r_tbl_n_in[r_layer];
  assign w_n_out = r_tbl_n_out[r_layer];
  assign w_end   = PW'(r_tbl_w_base[r_layer]) + PW'(w_n_in) * PW'(w_n_out);
  assign w_cfg_bad = (r_num_layers == '0) || (r_num_layers > L_MAX) ||
                     (w_n_in == '0) || (w_n_in > N_MAX) ||
                     (w_n_out == '0) || (w_n_out > N_MAX) || (w_end > W_LIM);

  // Engine-side outputs come straight from registers that only move outside ISSUE/WAIT.
  assign o_eng_w_base   = r_w_ptr;
  assign o_eng_n_in     = r_n_in;
  assign o_eng_in_bank  = r_bank;
  assign o_eng_out_addr = r_neuron[I_ADDR_LEN-1:0];

  // Config table: writable by the host only while the sequencer is idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < MAX_LAYERS; i++) begin
        r_tbl_n_in[i]   <= '0;
        r_tbl_n_out[i]  <= '0;
        r_tbl_w_base[i] <= '0;
      end
    end else if (i_cfg_we && (r_state == S_IDLE)) begin
      r_tbl_n_in[i_cfg_idx]   <= i_cfg_n_in;
      r_tbl_n_out[i_cfg_idx]  <= i_cfg_n_out;
      r_tbl_w_base[i_cfg_idx] <= i_cfg_w_base;
    end
  end

  // Sequencer FSM with registered host/engine handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_num_layers  <= '0;
      r_layer       <= '0;
      r_neuron      <= '0;
      r_n_in        <= '0;
      r_n_out       <= '0;
      r_w_ptr       <= '0;
      r_bank        <= 1'b0;
      r_tmo         <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
      o_result_bank <= 1'b0;
      o_eng_start   <= 1'b0;
    end else begin
      o_eng_start <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      if (i_abort) begin
        r_state <= S_IDLE;
        o_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_num_layers <= i_num_layers;
              r_layer      <= '0;
              r_neuron     <= '0;
              r_bank       <= 1'b0;
              r_w_ptr      <= r_tbl_w_base[0];
              o_busy       <= 1'b1;
              r_state      <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (w_cfg_bad) begin
              o_done        <= 1'b1;
              o_err         <= 1'b1;
              o_result_bank <= ~r_bank;
              r_state       <= S_DONE;
            end else begin
              r_n_in      <= w_n_in;
              r_n_out     <= w_n_out;
              o_eng_start <= 1'b1;
              r_state     <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            r_tmo   <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (i_eng_finish) begin
              r_state <= S_NEXT_N;
            end else if (r_tmo == T_END) begin
              o_done        <= 1'b1;
              o_err         <= 1'b1;
              o_result_bank <= ~r_bank;
              r_state       <= S_DONE;
            end else begin
              r_tmo <= r_tmo + TMO_W'(1);
            end
          end
          S_NEXT_N: begin
            r_neuron <= r_neuron + NW'(1);
            r_w_ptr  <= r_w_ptr + W_ADDR_LEN'(r_n_in);
            if (r_neuron == r_n_out - NW'(1)) begin
              r_state <= S_NEXT_L;
            end else begin
              o_eng_start <= 1'b1;
              r_state     <= S_ISSUE;
            end
          end
          S_NEXT_L: begin
            r_layer  <= r_layer + LIDX_W'(1);
            r_bank   <= ~r_bank;
            r_neuron <= '0;
            r_w_ptr  <= r_tbl_w_base[r_layer + LIDX_W'(1)];
            if ({1'b0, r_layer} == r_num_layers - LW'(1)) begin
              o_done        <= 1'b1;
              o_result_bank <= ~r_bank;
              r_state       <= S_DONE;
            end else begin
              r_state <= S_CHECK;
            end
          end
          S_DONE: begin
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
